// File: rtl/mem_bus_arbiter_if.sv
// Shared memory bus between two requesting masters, the arbiter and a fixed-latency memory port.
// Handshake: mX_req is held with its fields stable until the one-cycle mX_gnt; mX_done pulses once when the access completes.
interface mem_bus_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [2:0]  m0_option;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_done;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_we;
    logic [2:0]  m1_option;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_done;
    logic [31:0] m1_rdata;

    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_option;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_option, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_option, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_gnt, m0_done, m0_rdata,
        output m1_gnt, m1_done, m1_rdata,
        output mem_read, mem_write, mem_option, mem_addr, mem_wdata
    );

    modport master (
        output m0_req, m0_we, m0_option, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_option, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_gnt, m0_done, m0_rdata,
        input  m1_gnt, m1_done, m1_rdata,
        input  mem_read, mem_write, mem_option, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin two-master arbiter that sequences one access at a time through a fixed-latency memory port.
module mem_bus_arbiter #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_we_q, req_we_d;
    logic [2:0]  req_option_q, req_option_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        win;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            req_we_q     <= 1'b0;
            req_option_q <= 3'd0;
            req_addr_q   <= 32'd0;
            req_wdata_q  <= 32'd0;
            m0_rdata_q   <= 32'd0;
            m1_rdata_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            req_we_q     <= req_we_d;
            req_option_q <= req_option_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        req_we_d     = req_we_q;
        req_option_d = req_option_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        win          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    // On a tie the master that did not win last time goes next.
                    win          = (bus.m0_req && bus.m1_req) ? ~last_grant_q : bus.m1_req;
                    owner_d      = win;
                    last_grant_d = win;
                    req_we_d     = win ? bus.m1_we     : bus.m0_we;
                    req_option_d = win ? bus.m1_option : bus.m0_option;
                    req_addr_d   = win ? bus.m1_addr   : bus.m0_addr;
                    req_wdata_d  = win ? bus.m1_wdata  : bus.m0_wdata;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (req_we_q) begin
                    state_d = ST_RESPOND;
                end else begin
                    cnt_d   = 4'(READ_LATENCY);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (owner_q) m1_rdata_d = bus.mem_rdata;
                    else         m0_rdata_d = bus.mem_rdata;
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All handshake outputs decode registered state only, so no input reaches them combinationally.
    assign bus.m0_gnt     = (state_q == ST_ACCESS)  && !owner_q;
    assign bus.m1_gnt     = (state_q == ST_ACCESS)  &&  owner_q;
    assign bus.m0_done    = (state_q == ST_RESPOND) && !owner_q;
    assign bus.m1_done    = (state_q == ST_RESPOND) &&  owner_q;
    assign bus.mem_write  = (state_q == ST_ACCESS)  &&  req_we_q;
    assign bus.mem_read   = (state_q == ST_ACCESS)  && !req_we_q;
    assign bus.mem_option = req_option_q;
    assign bus.mem_addr   = req_addr_q;
    assign bus.mem_wdata  = req_wdata_q;
    assign bus.m0_rdata   = m0_rdata_q;
    assign bus.m1_rdata   = m1_rdata_q;
    assign dbg_state      = state_q;

endmodule
